// File: rtl/count_wrap_monitor_pkg.sv
// ----------------------------------------------------------------------------
// count_wrap_monitor_pkg
//
// Shared definitions for the counter wrap monitor:
//   - counter and statistic widths
//   - event-code constants carried on evt_code
//   - monitor FSM state encoding
//   - step classification used to interpret the sample-to-sample delta
//   - saturating increment helpers for the statistic counters
// ----------------------------------------------------------------------------
package count_wrap_monitor_pkg;

    // Width of the monitored up/down counter.
    localparam int unsigned CountWidth = 3;
    // Width of the overflow / underflow statistic counters.
    localparam int unsigned StatWidth  = 8;
    // Width of the dropped-event counter.
    localparam int unsigned DropWidth  = 4;
    // Width of the event code.
    localparam int unsigned CodeWidth  = 2;

    typedef logic [CountWidth-1:0] count_t;
    typedef logic [StatWidth-1:0]  stat_t;
    typedef logic [DropWidth-1:0]  drop_t;
    typedef logic [CodeWidth-1:0]  evt_code_t;

    // Largest counter value; a delta equal to this is a single down step.
    localparam count_t CountMax = {CountWidth{1'b1}};
    localparam count_t CountMin = '0;

    // Event codes. EVT_NONE is what evt_code shows whenever the slot is empty.
    localparam evt_code_t EVT_NONE = 2'b00;
    localparam evt_code_t EVT_OVF  = 2'b01;
    localparam evt_code_t EVT_UNF  = 2'b10;
    localparam evt_code_t EVT_ERR  = 2'b11;

    // StInit: no previous sample held yet. StTrack: prev is valid.
    typedef enum logic [0:0] {
        StInit  = 1'b0,
        StTrack = 1'b1
    } state_e;

    // Interpretation of (count - prev) mod 2^CountWidth.
    typedef enum logic [1:0] {
        StepHold = 2'b00,
        StepUp   = 2'b01,
        StepDown = 2'b10,
        StepJump = 2'b11
    } step_e;

    function automatic step_e classify_step(input count_t delta);
        step_e step;
        if (delta == count_t'(0)) begin
            step = StepHold;
        end else if (delta == count_t'(1)) begin
            step = StepUp;
        end else if (delta == CountMax) begin
            step = StepDown;
        end else begin
            step = StepJump;
        end
        return step;
    endfunction

    function automatic stat_t sat_inc_stat(input stat_t value);
        return (value == {StatWidth{1'b1}}) ? value : value + stat_t'(1);
    endfunction

    function automatic drop_t sat_inc_drop(input drop_t value);
        return (value == {DropWidth{1'b1}}) ? value : value + drop_t'(1);
    endfunction

endpackage

// File: rtl/evt_slot.sv
// ----------------------------------------------------------------------------
// evt_slot
//
// Single-entry event holding register with a valid/ready consumer handshake.
// A pushed event is accepted when the slot is empty or is being consumed on
// the same edge; otherwise it is discarded and counted in drop_cnt
// (saturating). The held code never changes while valid and not consumed,
// and reads as EVT_NONE whenever the slot is empty.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (wins over any handshake)
//   push       in   a new event is offered this cycle
//   push_code  in   code of the offered event
//   ready      in   consumer accepts the held event
//   valid      out  slot holds an event
//   code       out  held event code, EVT_NONE when empty
//   drop_cnt   out  saturating count of events lost to backpressure
// ----------------------------------------------------------------------------
module evt_slot
    import count_wrap_monitor_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [CodeWidth-1:0] push_code,
    input  logic                 ready,
    output logic                 valid,
    output logic [CodeWidth-1:0] code,
    output logic [DropWidth-1:0] drop_cnt
);

    logic      valid_q, valid_d;
    evt_code_t code_q, code_d;
    drop_t     drop_q, drop_d;

    logic consume;
    logic accept;

    // A consume frees the slot on this very edge, so a push alongside it
    // replaces the outgoing event rather than being dropped.
    assign consume = valid_q && ready;
    assign accept  = push && (!valid_q || consume);

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        drop_d  = drop_q;

        if (accept) begin
            valid_d = 1'b1;
            code_d  = push_code;
        end else if (consume) begin
            valid_d = 1'b0;
            code_d  = EVT_NONE;
        end

        if (push && !accept) begin
            drop_d = sat_inc_drop(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            code_q  <= EVT_NONE;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            drop_q  <= drop_d;
        end
    end

    assign valid    = valid_q;
    assign code     = code_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/count_wrap_monitor.sv
// ----------------------------------------------------------------------------
// count_wrap_monitor
//
// Watches a 3-bit up/down counter sampled every rising edge and classifies
// each step against the previous sample: hold, single up step, single down
// step, or illegal jump. 7->0 wraps are counted as overflows, 0->7 wraps as
// underflows, and illegal jumps set a sticky error. Overflow, underflow and
// illegal-jump events are offered to a single-entry event slot (evt_slot).
//
// Ports
//   clk        in   rising-edge clock shared with the counter
//   rst        in   synchronous active-high reset
//   count      in   counter value
//   evt_ready  in   consumer accepts the pending event
//   evt_valid  out  event slot holds an event
//   evt_code   out  01 overflow, 10 underflow, 11 illegal jump, 00 empty
//   dir        out  last inferred direction (1 up, 0 down)
//   ovf_cnt    out  saturating count of 7->0 wraps
//   unf_cnt    out  saturating count of 0->7 wraps
//   drop_cnt   out  saturating count of events lost to backpressure
//   err        out  sticky illegal-jump flag, cleared only by rst
// ----------------------------------------------------------------------------
module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CountWidth-1:0] count,
    input  logic                  evt_ready,
    output logic                  evt_valid,
    output logic [CodeWidth-1:0]  evt_code,
    output logic                  dir,
    output logic [StatWidth-1:0]  ovf_cnt,
    output logic [StatWidth-1:0]  unf_cnt,
    output logic [DropWidth-1:0]  drop_cnt,
    output logic                  err
);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The edge after reset only captures a reference
    // sample, so a counter that was reset alongside us is never mistaken
    // for an illegal jump.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  state_d = StTrack;
            StTrack: state_d = StTrack;
            default: state_d = StInit;
        endcase
    end

    // ------------------------------------------------------------------
    // Tracking registers
    // ------------------------------------------------------------------
    count_t prev_q, prev_d;
    logic   dir_q, dir_d;
    stat_t  ovf_q, ovf_d;
    stat_t  unf_q, unf_d;
    logic   err_q, err_d;

    count_t    delta;
    step_e     step;
    logic      evt_push;
    evt_code_t evt_push_code;

    // Modular subtraction: the 3-bit result is already delta mod 8.
    assign delta = count - prev_q;
    assign step  = classify_step(delta);

    // ------------------------------------------------------------------
    // FSM: outputs / classification
    // ------------------------------------------------------------------
    always_comb begin
        prev_d        = count;
        dir_d         = dir_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        err_d         = err_q;
        evt_push      = 1'b0;
        evt_push_code = EVT_NONE;

        if (state_q == StTrack) begin
            unique case (step)
                StepHold: begin
                end
                StepUp: begin
                    dir_d = 1'b1;
                    if (prev_q == CountMax && count == CountMin) begin
                        ovf_d         = sat_inc_stat(ovf_q);
                        evt_push      = 1'b1;
                        evt_push_code = EVT_OVF;
                    end
                end
                StepDown: begin
                    dir_d = 1'b0;
                    if (prev_q == CountMin && count == CountMax) begin
                        unf_d         = sat_inc_stat(unf_q);
                        evt_push      = 1'b1;
                        evt_push_code = EVT_UNF;
                    end
                end
                StepJump: begin
                    err_d         = 1'b1;
                    evt_push      = 1'b1;
                    evt_push_code = EVT_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            dir_q  <= 1'b1;
            ovf_q  <= '0;
            unf_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            dir_q  <= dir_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            err_q  <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Event slot
    // ------------------------------------------------------------------
    evt_slot u_evt_slot (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_code (evt_push_code),
        .ready     (evt_ready),
        .valid     (evt_valid),
        .code      (evt_code),
        .drop_cnt  (drop_cnt)
    );

    assign dir     = dir_q;
    assign ovf_cnt = ovf_q;
    assign unf_cnt = unf_q;
    assign err     = err_q;

endmodule

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the 3-bit up/down counter.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 count  input  3  counter value, sampled every rising edge.
REQ-005 evt_ready  input  1  consumer accepts the pending event.
REQ-006 evt_valid  output  1  event slot holds an event.
REQ-007 evt_code  output  2  event type: 01 overflow, 10 underflow, 11 illegal jump.
REQ-008 dir  output  1  last inferred direction: 1 up, 0 down.
REQ-009 ovf_cnt  output  8  saturating count of 7->0 wraps.
REQ-010 unf_cnt  output  8  saturating count of 0->7 wraps.
REQ-011 drop_cnt  output  4  saturating count of events lost to backpressure.
REQ-012 err  output  1  sticky illegal-jump flag.

Function
REQ-013 The FSM SHALL have two states: INIT (no previous sample held) and TRACK.
REQ-014 In INIT, the first edge SHALL load prev <= count, go to TRACK, and classify nothing.
REQ-015 In TRACK, each edge SHALL compute delta = (count - prev) mod 8 and then load prev <= count.
REQ-016 delta 0: hold; no event; dir unchanged.
REQ-017 delta 1: up step; dir <= 1; if prev=7 and count=0, ovf_cnt increments and an overflow event is raised.
REQ-018 delta 7: down step; dir <= 0; if prev=0 and count=7, unf_cnt increments and an underflow event is raised.
REQ-019 Any other delta: illegal jump; err <= 1; an illegal-jump event is raised; dir unchanged.
REQ-020 All outputs SHALL be registered; an event is visible on evt_valid/evt_code after the same edge that sampled the offending count (one-cycle latency from count change to sample, zero further).
REQ-021 ovf_cnt and unf_cnt SHALL saturate at 255; drop_cnt SHALL saturate at 15.
REQ-022 The event slot SHALL be consumed at an edge where evt_valid=1 and evt_ready=1.
REQ-023 A new event SHALL load the slot if the slot is empty or is consumed on the same edge.
REQ-024 If the slot is full and not consumed, a new event SHALL be dropped, drop_cnt increments, and the held event SHALL stay unchanged.
REQ-025 evt_code SHALL hold stable while evt_valid=1 and not consumed; evt_code is 00 when evt_valid=0.
REQ-026 err SHALL clear only on rst.

Reset
REQ-027 rst=1 at an edge SHALL force state INIT, prev=0, dir=1, ovf_cnt=0, unf_cnt=0, drop_cnt=0, err=0, evt_valid=0, evt_code=00.
REQ-028 rst SHALL take priority over all classification and handshake activity on the same edge, including a pending consume.
REQ-029 The first edge after rst deasserts SHALL be treated as INIT, so a counter reset mid-run SHALL NOT raise a false illegal-jump event.

Structure
REQ-030 A shared package SHALL hold the event-code constants (EVT_NONE, EVT_OVF, EVT_UNF, EVT_ERR), the count width (3), the statistic widths (8, 4), and the state encoding.
REQ-031 The single-entry event slot with valid/ready and drop counting SHALL be a sub-module named evt_slot; classification stays in count_wrap_monitor.

Verification
REQ-032 Reset, then count 0,1,...,7,0 one value per cycle with evt_ready=1 -> after the 0 sample: ovf_cnt=1, dir=1, evt_valid=1 for one cycle with evt_code=01.
REQ-033 Count 1,0,7,6 with evt_ready=1 -> unf_cnt=1, dir=0, one event with evt_code=10.
REQ-034 Count 2 then 5 -> err=1 and evt_code=11; err stays 1 through further legal steps until rst.
REQ-035 evt_ready=0 and two overflows -> first event held with evt_code=01, drop_cnt=1; raise evt_ready -> slot empties next edge.
REQ-036 Run 260 up-wraps with evt_ready=1 -> ovf_cnt=255. Then assert rst for one cycle with count jumping 6->0 -> all outputs at reset values and no event raised.
